// File: rtl/skew_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : skew_phase_scheduler
// Brief    : Generates two square-wave strobes with a programmable half-period.
//            out2 lags out1 by a programmable skew. Generation is started and
//            stopped by level-sampled controls. A stop lets each strobe finish
//            its current high phase. Configuration is loaded over a
//            valid/ready handshake and is accepted only while idle.
// Revision : 1.0 - initial release
// ============================================================================
module skew_phase_scheduler #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 5,
  parameter int DEF_SKEW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W-1:0] cfg_skew,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             out1,
  output logic             out2,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] c_def_skew = CNT_W'(DEF_SKEW);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero     = '0;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_skew;
  logic             r_cfg_err;

  // Channel 1: phase counter and strobe
  logic [CNT_W-1:0] r_cnt1;
  logic             r_out1;

  // Channel 2: skew delay counter, then a phase counter identical to channel 1
  logic [CNT_W-1:0] r_dly_cnt;
  logic             r_dly_done;
  logic [CNT_W-1:0] r_cnt2;
  logic             r_out2;

  logic             w_idle;
  logic             w_xfer;
  logic             w_cfg_ok;
  logic             w_stopping;
  logic [CNT_W-1:0] w_half_m1;
  logic [CNT_W-1:0] w_skew_m1;
  logic [CNT_W-1:0] w_skew_eff;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_xfer    = cfg_valid && w_idle;
  // Compare one bit wider so 2*cfg_half cannot overflow.
  assign w_cfg_ok  = (cfg_half != c_zero) &&
                     ({1'b0, cfg_skew} < {cfg_half, 1'b0});
  // Skew that RUN will use if a launch happens this cycle. A config accepted
  // on the same edge as start takes effect immediately.
  assign w_skew_eff = (w_xfer && w_cfg_ok) ? cfg_skew : r_skew;
  assign w_half_m1  = r_half - c_one;
  assign w_skew_m1  = r_skew - c_one;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus status flags derived from the state. w_stopping
  // is also raised on the edge that samples stop in RUN, so a low channel
  // freezes at once and never produces one more rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_stopping  = 1'b0;
    busy        = 1'b1;
    cfg_ready   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (start && !stop) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_STOPPING;
          w_stopping  = 1'b1;
        end
      end
      ST_STOPPING: begin
        w_stopping = 1'b1;
        if (!r_out1 && !r_out2) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Configuration registers and the one-cycle reject pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half    <= c_def_half;
      r_skew    <= c_def_skew;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= w_xfer && !w_cfg_ok;
      if (w_xfer && w_cfg_ok) begin
        r_half <= cfg_half;
        r_skew <= cfg_skew;
      end
    end
  end

  // Channel 1: the strobe toggles when the phase counter reaches half-1.
  // While stopping, a low strobe stays frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt1 <= c_zero;
      r_out1 <= 1'b0;
    end else if (w_idle) begin
      r_cnt1 <= c_zero;
      r_out1 <= 1'b0;
    end else if (w_stopping && !r_out1) begin
      r_cnt1 <= c_zero;
    end else if (r_cnt1 == w_half_m1) begin
      r_cnt1 <= c_zero;
      r_out1 <= ~r_out1;
    end else begin
      r_cnt1 <= r_cnt1 + c_one;
    end
  end

  // Channel 2: hold low for skew cycles, then run exactly like channel 1.
  // Once stopping, a channel still in its delay never starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_cnt  <= c_zero;
      r_dly_done <= 1'b0;
      r_cnt2     <= c_zero;
      r_out2     <= 1'b0;
    end else if (w_idle) begin
      r_dly_cnt  <= c_zero;
      r_dly_done <= (w_skew_eff == c_zero);
      r_cnt2     <= c_zero;
      r_out2     <= 1'b0;
    end else if (!r_dly_done) begin
      if (!w_stopping) begin
        if (r_dly_cnt == w_skew_m1) begin
          r_dly_cnt  <= c_zero;
          r_dly_done <= 1'b1;
        end else begin
          r_dly_cnt <= r_dly_cnt + c_one;
        end
      end
    end else if (w_stopping && !r_out2) begin
      r_cnt2 <= c_zero;
    end else if (r_cnt2 == w_half_m1) begin
      r_cnt2 <= c_zero;
      r_out2 <= ~r_out2;
    end else begin
      r_cnt2 <= r_cnt2 + c_one;
    end
  end

  assign out1    = r_out1;
  assign out2    = r_out2;
  assign cfg_err = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_skew_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_skew_phase_scheduler
// Brief    : Randomized and directed stimulus for skew_phase_scheduler.
//            Outputs are compared every cycle against a waveform-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_skew_phase_scheduler;

  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 5;
  localparam int DEF_SKEW = 3;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_STOP   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [CNT_W-1:0] cfg_skew = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cfg_ready;
  logic             cfg_err;
  logic             out1;
  logic             out2;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: mode, cycles since RUN began, config, outputs
  int m_mode;
  int m_t;
  int m_half;
  int m_skew;
  bit m_o1;
  bit m_o2;
  bit m_err;

  always #5 clk = ~clk;

  skew_phase_scheduler #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF),
    .DEF_SKEW (DEF_SKEW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_half  (cfg_half),
    .cfg_skew  (cfg_skew),
    .cfg_err   (cfg_err),
    .start     (start),
    .stop      (stop),
    .out1      (out1),
    .out2      (out2),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ideal free-running waveforms, t = cycles since entering RUN
  function automatic bit nom1(input int t);
    return ((t / m_half) % 2) == 1;
  endfunction

  function automatic bit nom2(input int t);
    return (t >= m_skew) && nom1(t - m_skew);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_t    = 0;
    m_half = DEF_HALF;
    m_skew = DEF_SKEW;
    m_o1   = 1'b0;
    m_o2   = 1'b0;
    m_err  = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present at the edge
  task automatic model_advance();
    bit err_n;
    err_n = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (cfg_valid) begin
          if (cfg_half != 0 && int'(cfg_skew) < 2 * int'(cfg_half)) begin
            m_half = int'(cfg_half);
            m_skew = int'(cfg_skew);
          end else begin
            err_n = 1'b1;
          end
        end
        if (start && !stop) begin
          m_mode = M_RUN;
          m_t    = 0;
          m_o1   = 1'b0;
          m_o2   = 1'b0;
        end
      end
      M_RUN: begin
        m_t++;
        if (stop) begin
          m_mode = M_STOP;
          m_o1   = m_o1 && nom1(m_t);
          m_o2   = m_o2 && nom2(m_t);
        end else begin
          m_o1 = nom1(m_t);
          m_o2 = nom2(m_t);
        end
      end
      default: begin
        if (!m_o1 && !m_o2) begin
          m_mode = M_IDLE;
        end else begin
          m_t++;
          m_o1 = m_o1 && nom1(m_t);
          m_o2 = m_o2 && nom2(m_t);
        end
      end
    endcase
    m_err = err_n;
  endtask

  task automatic compare(input string tag);
    check_val(tag, {27'd0, out1, out2, busy, cfg_ready, cfg_err},
              {27'd0, m_o1, m_o2, (m_mode != M_IDLE), (m_mode == M_IDLE), m_err});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_advance();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic set_cfg(input int h, input int s, input bit with_start);
    cfg_valid = 1'b1;
    cfg_half  = CNT_W'(h);
    cfg_skew  = CNT_W'(s);
    start     = with_start;
    step("cfg");
    cfg_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 1500 && (m_mode != M_IDLE || busy); i++) begin
      step(tag);
    end
    check_val("idle_timeout", busy, 1'b0);
  endtask

  task automatic run_defaults(input string tag);
    start = 1'b1;
    step(tag);
    start = 1'b0;
    repeat (20) step(tag);
    stop = 1'b1;
    step(tag);
    stop = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int h;
    int s;
    int n;
    int hi;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compare("reset");
    rst_n = 1'b1;
    step("idle");

    // Default waveform with absolute edge times
    start = 1'b1;
    step("def_start");
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step("def_run");
      case (m_t)
        4:  check_val("def_o1_t4", out1, 1'b0);
        5:  check_val("def_o1_t5", out1, 1'b1);
        7:  check_val("def_o2_t7", out2, 1'b0);
        8:  check_val("def_o2_t8", out2, 1'b1);
        10: check_val("def_o1_t10", out1, 1'b0);
        13: check_val("def_o2_t13", out2, 1'b0);
        15: check_val("def_o1_t15", out1, 1'b1);
        default: ;
      endcase
    end
    stop = 1'b1;
    step("def_stop");
    stop = 1'b0;
    wait_idle("def_drain");

    // Zero skew: both strobes identical
    set_cfg(4, 0, 1'b0);
    start = 1'b1;
    step("z_start");
    start = 1'b0;
    repeat (40) step("z_run");
    stop = 1'b1;
    step("z_stop");
    stop = 1'b0;
    wait_idle("z_drain");

    // Rejected configs leave registers at the defaults
    model_reset();
    rst_n = 1'b0;
    step("rst2");
    rst_n = 1'b1;
    step("rst2_rel");
    set_cfg(5, 10, 1'b0);
    step("err1_after");
    set_cfg(0, 0, 1'b0);
    step("err2_after");
    run_defaults("after_err");

    // Stop at t=9 with defaults
    start = 1'b1;
    step("s9_start");
    start = 1'b0;
    repeat (9) step("s9_run");
    check_val("s9_t", m_t, 9);
    stop = 1'b1;
    step("s9_stop");
    stop = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step("s9_drain");
      if (m_t == 14 || m_mode == M_IDLE) begin
        check_val("s9_busy_low", busy, 1'b0);
        break;
      end
    end
    wait_idle("s9_tail");

    // start+stop together in IDLE, then start held through RUN
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) step("ss_idle");
    stop = 1'b0;
    repeat (25) step("hold_start");
    start = 1'b0;
    stop  = 1'b1;
    step("hold_stop");
    stop = 1'b0;
    wait_idle("hold_drain");

    // Asynchronous reset at t=12 with half=6
    set_cfg(6, 3, 1'b0);
    start = 1'b1;
    step("ar_start");
    start = 1'b0;
    repeat (12) step("ar_run");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare("async_rst");
    step("ar_hold");
    step("ar_hold");
    rst_n = 1'b1;
    step("ar_rel");
    run_defaults("ar_def");

    // Randomized sessions
    for (int it = 0; it < 40; it++) begin
      h  = ($urandom_range(15, 0) == 0) ? 255 : int'($urandom_range(12, 0));
      hi = 2 * h + 1;
      if (hi > 255) hi = 255;
      s  = int'($urandom_range(hi, 0));
      if ($urandom_range(1, 0) == 1) begin
        set_cfg(h, s, 1'b1);
      end else begin
        set_cfg(h, s, 1'b0);
        if ($urandom_range(2, 0) == 0) begin
          start = 1'b1;
          stop  = 1'b1;
          step("r_ss");
          stop  = 1'b0;
        end
        start = 1'b1;
        step("r_start");
        start = 1'b0;
      end
      n = int'($urandom_range(3 * m_half + m_skew + 2, 0));
      if (n > 800) n = 800;
      for (int k = 0; k < n; k++) begin
        start     = $urandom_range(1, 0) == 1;
        cfg_valid = $urandom_range(3, 0) == 0;
        cfg_half  = CNT_W'($urandom_range(255, 0));
        cfg_skew  = CNT_W'($urandom_range(255, 0));
        step("r_run");
      end
      start     = 1'b0;
      cfg_valid = 1'b0;
      stop      = 1'b1;
      step("r_stop");
      stop = 1'b0;
      wait_idle("r_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
